// File: rtl/wait_buffer_refill_ctrl.sv
// Refill sequencer for the non-blocking data cache wait buffer: walks pending
// entries of a returning block, merges stores into a line copy and queues load results.
module wait_buffer_refill_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_BITS      = 32,
    parameter int BLOCK_ID_START = 5,
    parameter int R_WIDTH        = 6,
    parameter int MICROOP        = 5,
    parameter int ROB_TICKET     = 3,
    parameter int DEPTH          = 8,
    localparam int BLOCK_W       = 8 << BLOCK_ID_START
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fill_valid,
    input  logic [ADDR_BITS-1:0]  fill_address,
    input  logic [BLOCK_W-1:0]    fill_block,
    output logic                  fill_ready,
    output logic [ADDR_BITS-1:0]  wb_search_address,
    output logic                  wb_search_invalidate,
    input  logic                  wb_in_walk_mode,
    input  logic                  wb_found_one,
    input  logic                  wb_found_multi,
    input  logic                  wb_is_store,
    input  logic [ADDR_BITS-1:0]  wb_address_o,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [MICROOP-1:0]    wb_microop,
    input  logic [R_WIDTH-1:0]    wb_dest,
    input  logic [ROB_TICKET-1:0] wb_ticket,
    output logic                  line_valid,
    input  logic                  line_ready,
    output logic [ADDR_BITS-1:0]  line_address,
    output logic [BLOCK_W-1:0]    line_data,
    output logic                  ld_valid,
    input  logic                  ld_ready,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic [R_WIDTH-1:0]    ld_dest,
    output logic [ROB_TICKET-1:0] ld_ticket
);

    localparam int OFF_W   = BLOCK_ID_START;
    localparam int WI_W    = OFF_W - 2;
    localparam int HI_W    = OFF_W - 1;
    localparam int NWORDS  = BLOCK_W / 32;
    localparam int NHALVES = BLOCK_W / 16;
    localparam int NBYTES  = BLOCK_W / 8;
    localparam int TAG_W   = ADDR_BITS - OFF_W;
    localparam int ENTRY_W = DATA_WIDTH + R_WIDTH + ROB_TICKET;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WALK  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;

    localparam logic [MICROOP-1:0] OP_LW  = MICROOP'(1);
    localparam logic [MICROOP-1:0] OP_LH  = MICROOP'(2);
    localparam logic [MICROOP-1:0] OP_LHU = MICROOP'(3);
    localparam logic [MICROOP-1:0] OP_LB  = MICROOP'(4);
    localparam logic [MICROOP-1:0] OP_LBU = MICROOP'(5);
    localparam logic [MICROOP-1:0] OP_SW  = MICROOP'(6);
    localparam logic [MICROOP-1:0] OP_SH  = MICROOP'(7);
    localparam logic [MICROOP-1:0] OP_SB  = MICROOP'(8);

    logic [2:0]         state_q, state_d;
    logic [TAG_W-1:0]   addr_q, addr_d;
    logic [BLOCK_W-1:0] line_q, line_d;
    logic               walk_first_q, walk_first_d;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];

    logic               fifo_empty;
    logic               fifo_full;
    logic               load_push;
    logic               load_pop;
    logic [DATA_WIDTH-1:0] load_data;
    logic [ENTRY_W-1:0] fifo_head;

    // Peeked entry decode
    logic [OFF_W-1:0]   offset;
    logic [WI_W-1:0]    word_idx;
    logic [HI_W-1:0]    half_idx;
    logic               walk_proc;
    logic               do_sw, do_sh, do_sb;

    assign offset    = wb_address_o[OFF_W-1:0];
    assign word_idx  = offset[OFF_W-1:2];
    assign half_idx  = offset[OFF_W-1:1];
    assign walk_proc = (state_q == S_WALK) && wb_in_walk_mode;
    assign do_sw     = walk_proc && (wb_microop == OP_SW);
    assign do_sh     = walk_proc && (wb_microop == OP_SH);
    assign do_sb     = walk_proc && (wb_microop == OP_SB);

    logic [31:0]        line_words  [NWORDS];
    logic [15:0]        line_halves [NHALVES];
    logic [7:0]         line_bytes  [NBYTES];
    logic [BLOCK_W-1:0] merged_line;

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_words
            assign line_words[gi] = line_q[32*gi +: 32];
        end
        for (gi = 0; gi < NHALVES; gi++) begin : g_halves
            assign line_halves[gi] = line_q[16*gi +: 16];
        end
        // Each byte lane picks its new value from whichever sized store covers it.
        for (gi = 0; gi < NBYTES; gi++) begin : g_lanes
            logic lane_sw, lane_sh, lane_sb;
            assign line_bytes[gi] = line_q[8*gi +: 8];
            assign lane_sw = do_sw && (word_idx == WI_W'(gi / 4));
            assign lane_sh = do_sh && (half_idx == HI_W'(gi / 2));
            assign lane_sb = do_sb && (offset == OFF_W'(gi));
            assign merged_line[8*gi +: 8] = lane_sw ? wb_data[8*(gi % 4) +: 8] :
                                            lane_sh ? wb_data[8*(gi % 2) +: 8] :
                                            lane_sb ? wb_data[7:0] :
                                                      line_bytes[gi];
        end
    endgenerate

    logic [31:0] sel_word;
    logic [15:0] sel_half;
    logic [7:0]  sel_byte;

    assign sel_word = line_words[word_idx];
    assign sel_half = line_halves[half_idx];
    assign sel_byte = line_bytes[offset];

    always_comb begin
        load_push = 1'b0;
        load_data = '0;
        if (walk_proc) begin
            case (wb_microop)
                OP_LW: begin
                    load_push = 1'b1;
                    load_data = DATA_WIDTH'(sel_word);
                end
                OP_LH: begin
                    load_push = 1'b1;
                    load_data = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
                end
                OP_LHU: begin
                    load_push = 1'b1;
                    load_data = {{(DATA_WIDTH-16){1'b0}}, sel_half};
                end
                OP_LB: begin
                    load_push = 1'b1;
                    load_data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
                end
                OP_LBU: begin
                    load_push = 1'b1;
                    load_data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        line_d       = line_q;
        walk_first_d = walk_first_q;
        case (state_q)
            S_IDLE: begin
                // A new fill waits for the load FIFO to drain so a full walk cannot overflow it.
                if (fill_valid && fifo_empty) begin
                    addr_d  = fill_address[ADDR_BITS-1:OFF_W];
                    line_d  = fill_block;
                    state_d = wb_found_one ? S_START : S_ACK;
                end
            end
            S_START: begin
                walk_first_d = 1'b1;
                state_d      = S_WALK;
            end
            S_WALK: begin
                walk_first_d = 1'b0;
                if (wb_in_walk_mode) begin
                    line_d = merged_line;
                end else if (!walk_first_q) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (line_ready) begin
                    state_d = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            line_q       <= '0;
            walk_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            walk_first_q <= walk_first_d;
        end
    end

    assign wb_search_address    = (state_q == S_IDLE) ?
                                  {fill_address[ADDR_BITS-1:OFF_W], {OFF_W{1'b0}}} :
                                  {addr_q, {OFF_W{1'b0}}};
    assign wb_search_invalidate = (state_q == S_START);
    assign line_valid           = (state_q == S_WRITE);
    assign fill_ready           = (state_q == S_ACK);
    assign line_address         = {addr_q, {OFF_W{1'b0}}};
    assign line_data            = line_q;

    // Load result FIFO, first-word fall-through
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign load_pop   = ld_valid && ld_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (load_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (load_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({load_push, load_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_push) begin
            fifo_mem[wr_ptr_q] <= {load_data, wb_dest, wb_ticket};
        end
    end

    assign fifo_head = fifo_mem[rd_ptr_q];
    assign ld_valid  = !fifo_empty;
    assign ld_data   = ld_valid ? fifo_head[ENTRY_W-1 -: DATA_WIDTH] : '0;
    assign ld_dest   = ld_valid ? fifo_head[ROB_TICKET +: R_WIDTH] : '0;
    assign ld_ticket = ld_valid ? fifo_head[ROB_TICKET-1:0] : '0;

    no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(load_push && fifo_full));

    // Inputs that carry no information this controller needs
    logic unused_inputs;
    assign unused_inputs = ^{wb_is_store, wb_found_multi, fill_address[OFF_W-1:0],
                             wb_address_o[ADDR_BITS-1:OFF_W]};

endmodule

// File: tb/tb_wait_buffer_refill_ctrl.sv
// Directed bench for wait_buffer_refill_ctrl: a small wait-buffer driver feeds
// walks entry by entry and every expected value is hand-computed.
module tb_wait_buffer_refill_ctrl;

    logic         clk;
    logic         rst_n;
    logic         fill_valid;
    logic [31:0]  fill_address;
    logic [255:0] fill_block;
    logic         fill_ready;
    logic [31:0]  wb_search_address;
    logic         wb_search_invalidate;
    logic         wb_in_walk_mode;
    logic         wb_found_one;
    logic         wb_found_multi;
    logic         wb_is_store;
    logic [31:0]  wb_address_o;
    logic [31:0]  wb_data;
    logic [4:0]   wb_microop;
    logic [5:0]   wb_dest;
    logic [2:0]   wb_ticket;
    logic         line_valid;
    logic         line_ready;
    logic [31:0]  line_address;
    logic [255:0] line_data;
    logic         ld_valid;
    logic         ld_ready;
    logic [31:0]  ld_data;
    logic [5:0]   ld_dest;
    logic [2:0]   ld_ticket;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] e_addr [8];
    logic [31:0] e_data [8];
    logic [4:0]  e_op   [8];
    logic [5:0]  e_dest [8];
    logic [2:0]  e_tkt  [8];

    wait_buffer_refill_ctrl dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .fill_valid           (fill_valid),
        .fill_address         (fill_address),
        .fill_block           (fill_block),
        .fill_ready           (fill_ready),
        .wb_search_address    (wb_search_address),
        .wb_search_invalidate (wb_search_invalidate),
        .wb_in_walk_mode      (wb_in_walk_mode),
        .wb_found_one         (wb_found_one),
        .wb_found_multi       (wb_found_multi),
        .wb_is_store          (wb_is_store),
        .wb_address_o         (wb_address_o),
        .wb_data              (wb_data),
        .wb_microop           (wb_microop),
        .wb_dest              (wb_dest),
        .wb_ticket            (wb_ticket),
        .line_valid           (line_valid),
        .line_ready           (line_ready),
        .line_address         (line_address),
        .line_data            (line_data),
        .ld_valid             (ld_valid),
        .ld_ready             (ld_ready),
        .ld_data              (ld_data),
        .ld_dest              (ld_dest),
        .ld_ticket            (ld_ticket)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] pattern_block(input logic [31:0] base);
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[32*i +: 32] = base + 32'(i);
        return b;
    endfunction

    task automatic put_entry(input int i, input logic [31:0] a, input logic [4:0] op,
                             input logic [31:0] d, input logic [5:0] dst, input logic [2:0] t);
        e_addr[i] = a; e_op[i] = op; e_data[i] = d; e_dest[i] = dst; e_tkt[i] = t;
    endtask

    task automatic drive_entry(input int i);
        wb_address_o = e_addr[i];
        wb_microop   = e_op[i];
        wb_data      = e_data[i];
        wb_dest      = e_dest[i];
        wb_ticket    = e_tkt[i];
        wb_is_store  = (e_op[i] >= 5'd6) && (e_op[i] <= 5'd8);
    endtask

    task automatic clear_entry();
        wb_address_o = '0; wb_microop = '0; wb_data = '0;
        wb_dest = '0; wb_ticket = '0; wb_is_store = 1'b0;
    endtask

    // Starts and ends at a falling edge; the pending entries come from e_* [0..n-1].
    task automatic run_fill(input string name, input logic [31:0] addr, input logic [255:0] blk,
                            input int n, input int lr_delay, input logic [255:0] exp_line);
        fill_valid   = 1'b1;
        fill_address = addr;
        fill_block   = blk;
        wb_found_one = (n > 0);
        @(negedge clk);
        fill_valid   = 1'b0;
        wb_found_one = 1'b0;
        if (n > 0) begin
            n_checks++;
            if (wb_search_invalidate !== 1'b1) begin
                n_fail++;
                $display("FAIL %s invalidate: actual=%b required=1", name, wb_search_invalidate);
            end
            n_checks++;
            if (wb_search_address !== (addr & 32'hFFFF_FFE0)) begin
                n_fail++;
                $display("FAIL %s search_addr: actual=%h required=%h", name, wb_search_address, addr & 32'hFFFF_FFE0);
            end
            wb_in_walk_mode = 1'b1;
            drive_entry(0);
            @(negedge clk);
            n_checks++;
            if (wb_search_invalidate !== 1'b0) begin
                n_fail++;
                $display("FAIL %s invalidate_pulse: actual=%b required=0", name, wb_search_invalidate);
            end
            for (int i = 1; i < n; i++) begin
                @(negedge clk);
                drive_entry(i);
            end
            @(negedge clk);
            wb_in_walk_mode = 1'b0;
            clear_entry();
            @(negedge clk);
            for (int c = 0; c <= lr_delay; c++) begin
                n_checks++;
                if (line_valid !== 1'b1 || line_data !== exp_line || line_address !== (addr & 32'hFFFF_FFE0)) begin
                    n_fail++;
                    $display("FAIL %s line_hold%0d: actual v=%b a=%h d=%h required v=1 a=%h d=%h",
                             name, c, line_valid, line_address, line_data, addr & 32'hFFFF_FFE0, exp_line);
                end
                if (c == lr_delay) line_ready = 1'b1;
                @(negedge clk);
            end
            line_ready = 1'b0;
        end
        n_checks++;
        if (fill_ready !== 1'b1 || line_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ack: actual fill_ready=%b line_valid=%b required 1/0", name, fill_ready, line_valid);
        end
        @(negedge clk);
        n_checks++;
        if (fill_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ack_pulse: actual=%b required=0", name, fill_ready);
        end
        $display("fill %s addr=%h entries=%0d done", name, addr, n);
    endtask

    task automatic pop_expect(input string name, input logic [31:0] d, input logic [5:0] dst, input logic [2:0] t);
        n_checks++;
        if (ld_valid !== 1'b1 || ld_data !== d || ld_dest !== dst || ld_ticket !== t) begin
            n_fail++;
            $display("FAIL %s load: actual v=%b d=%h dst=%0d t=%0d required v=1 d=%h dst=%0d t=%0d",
                     name, ld_valid, ld_data, ld_dest, ld_ticket, d, dst, t);
        end
        $display("load %s data=%h dest=%0d ticket=%0d", name, ld_data, ld_dest, ld_ticket);
        ld_ready = 1'b1;
        @(negedge clk);
        ld_ready = 1'b0;
    endtask

    task automatic expect_fifo_empty(input string name);
        n_checks++;
        if (ld_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s fifo_empty: actual ld_valid=%b required=0", name, ld_valid);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if (fill_ready !== 1'b0 || wb_search_invalidate !== 1'b0 || line_valid !== 1'b0 || ld_valid !== 1'b0 ||
            line_address !== '0 || line_data !== '0 || ld_data !== '0 || ld_dest !== '0 || ld_ticket !== '0) begin
            n_fail++;
            $display("FAIL %s outputs: actual fr=%b inv=%b lv=%b ldv=%b la=%h ld=%h required all 0",
                     name, fill_ready, wb_search_invalidate, line_valid, ld_valid, line_address, ld_data);
        end
        n_checks++;
        if (wb_search_address !== '0) begin
            n_fail++;
            $display("FAIL %s search_addr: actual=%h required=0", name, wb_search_address);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fill_valid = 1'b0; fill_address = '0; fill_block = '0;
        wb_in_walk_mode = 1'b0; wb_found_one = 1'b0; wb_found_multi = 1'b0;
        clear_entry();
        line_ready = 1'b0; ld_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");
        $display("reset checked");
    endtask

    task automatic test_no_match();
        fill_valid = 1'b1; fill_address = 32'h1000; wb_found_one = 1'b0;
        #1;
        n_checks++;
        if (wb_search_address !== 32'h1000) begin
            n_fail++;
            $display("FAIL no_match idle_search: actual=%h required=00001000", wb_search_address);
        end
        n_checks++;
        if (fill_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL no_match early_ready: actual=%b required=0", fill_ready);
        end
        run_fill("no_match", 32'h1000, pattern_block(32'h0), 0, 0, '0);
        expect_fifo_empty("no_match");
    endtask

    task automatic test_single_lw();
        logic [255:0] blk;
        blk = pattern_block(32'h1000_0000);
        blk[64 +: 32] = 32'hDEADBEEF;
        put_entry(0, 32'h1008, 5'd1, 32'h0, 6'd17, 3'd5);
        run_fill("single_lw", 32'h1000, blk, 1, 0, blk);
        pop_expect("single_lw", 32'hDEADBEEF, 6'd17, 3'd5);
        expect_fifo_empty("single_lw");
    endtask

    task automatic test_store_then_load();
        logic [255:0] blk, exp;
        blk = pattern_block(32'h2000_0000);
        blk[0 +: 32] = 32'h11223344;
        exp = blk;
        exp[0 +: 32] = 32'h80223344;
        put_entry(0, 32'h2003, 5'd8, 32'h0000_0080, 6'd0, 3'd0);
        put_entry(1, 32'h2000, 5'd1, 32'h0, 6'd9, 3'd2);
        run_fill("st_ld", 32'h2000, blk, 2, 0, exp);
        pop_expect("st_ld", 32'h80223344, 6'd9, 3'd2);
        expect_fifo_empty("st_ld");
    endtask

    task automatic test_sign_ext();
        logic [255:0] blk, exp;
        blk = '0;
        blk[32 +: 32] = 32'h0000_F000;
        blk[64 +: 32] = 32'h8001_0000;
        exp = blk;
        exp[64 +: 32]  = 32'h7FFE_0000;
        exp[128 +: 32] = 32'hCAFE_F00D;
        put_entry(0, 32'h3005, 5'd4,  32'h0,         6'd1, 3'd1);
        put_entry(1, 32'h3005, 5'd5,  32'h0,         6'd2, 3'd2);
        put_entry(2, 32'h300A, 5'd2,  32'h0,         6'd3, 3'd3);
        put_entry(3, 32'h3000, 5'd31, 32'hFFFF_FFFF, 6'd4, 3'd4);
        put_entry(4, 32'h300B, 5'd7,  32'h1234_7FFE, 6'd0, 3'd0);
        put_entry(5, 32'h300A, 5'd2,  32'h0,         6'd5, 3'd5);
        put_entry(6, 32'h3010, 5'd6,  32'hCAFE_F00D, 6'd0, 3'd0);
        put_entry(7, 32'h3013, 5'd1,  32'h0,         6'd6, 3'd6);
        run_fill("sign_ext", 32'h3000, blk, 8, 0, exp);
        pop_expect("lb",      32'hFFFF_FFF0, 6'd1, 3'd1);
        pop_expect("lbu",     32'h0000_00F0, 6'd2, 3'd2);
        pop_expect("lh",      32'hFFFF_8001, 6'd3, 3'd3);
        pop_expect("lh_sh",   32'h0000_7FFE, 6'd5, 3'd5);
        pop_expect("lw_sw",   32'hCAFE_F00D, 6'd6, 3'd6);
        expect_fifo_empty("sign_ext");
    endtask

    task automatic test_backpressure();
        logic [255:0] blk;
        blk = pattern_block(32'hA000_0000);
        for (int i = 0; i < 8; i++) put_entry(i, 32'h4000 + 32'(4*i), 5'd1, 32'h0, 6'(10 + i), 3'(i));
        run_fill("backpressure", 32'h4000, blk, 8, 3, blk);
        fill_valid = 1'b1; fill_address = 32'h5000; wb_found_one = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (fill_ready !== 1'b0 || wb_search_address !== 32'h5000 || ld_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL blocked_fill%0d: actual fr=%b sa=%h ldv=%b required 0/00005000/1",
                         c, fill_ready, wb_search_address, ld_valid);
            end
        end
        for (int i = 0; i < 8; i++) pop_expect("drain", 32'hA000_0000 + 32'(i), 6'(10 + i), 3'(i));
        expect_fifo_empty("drain");
        n_checks++;
        if (fill_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_early_ack: actual=%b required=0", fill_ready);
        end
        @(negedge clk);
        fill_valid = 1'b0;
        n_checks++;
        if (fill_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL second_fill_ack: actual=%b required=1", fill_ready);
        end
        @(negedge clk);
        $display("backpressure second fill accepted after drain");
    endtask

    task automatic test_reset_mid_walk();
        for (int i = 0; i < 4; i++) put_entry(i, 32'h7000 + 32'(4*i), 5'd1, 32'h0, 6'(20 + i), 3'(i));
        fill_valid = 1'b1; fill_address = 32'h7000; fill_block = pattern_block(32'h7000_0000);
        wb_found_one = 1'b1;
        @(negedge clk);
        fill_valid = 1'b0; wb_found_one = 1'b0;
        wb_in_walk_mode = 1'b1;
        drive_entry(0);
        @(negedge clk);
        @(negedge clk);
        drive_entry(1);
        @(negedge clk);
        drive_entry(2);
        n_checks++;
        if (ld_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_walk_loads: actual ld_valid=%b required=1", ld_valid);
        end
        fill_address = '0;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_walk");
        @(negedge clk);
        wb_in_walk_mode = 1'b0;
        clear_entry();
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");
        run_fill("post_reset", 32'h8000, '0, 0, 0, '0);
        expect_fifo_empty("post_reset");
    endtask

    initial begin
        test_reset();
        test_no_match();
        test_single_lw();
        test_store_then_load();
        test_sign_ext();
        test_backpressure();
        test_reset_mid_walk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
